axi_lite_reg_slave: RTL
=======================

Name: axi_lite_reg_slave

Overview:
AXI4-Lite slave register bank that consumes the transactions driven by our AXI4-Lite master through the master modport of axi_lite_if. It decodes word addresses into NUM_REGS registers, applies WSTRB byte enables, and returns OKAY or SLVERR responses. Register contents and per-register write pulses are exported flat for the downstream control logic.

Parameters:
DATA_WIDTH, 32, data bus width; only 32 or 64 are legal.
ADDRESS_WIDTH, 32, address bus width.
NUM_REGS, 16, number of registers; must be >= 2. Register k sits at byte address k*(DATA_WIDTH/8).

Ports:
ACLK  input  1  clock
ARESETn  input  1  asynchronous active-low reset
AWADDR  input  ADDRESS_WIDTH  write address
AWPROT  input  3  write protection
AWVALID  input  1  write address valid
AWREADY  output  1  write address ready
WDATA  input  DATA_WIDTH  write data
WSTRB  input  DATA_WIDTH/8  byte strobes
WVALID  input  1  write data valid
WREADY  output  1  write data ready
BRESP  output  2  write response
BVALID  output  1  write response valid
BREADY  input  1  write response ready
ARADDR  input  ADDRESS_WIDTH  read address
ARPROT  input  3  read protection
ARVALID  input  1  read address valid
ARREADY  output  1  read address ready
RDATA  output  DATA_WIDTH  read data
RRESP  output  2  read response
RVALID  output  1  read valid
RREADY  input  1  read ready
reg_out  output  NUM_REGS*DATA_WIDTH  register k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
wr_pulse  output  NUM_REGS  one-cycle pulse per committed register write

Behaviour:
- Clocking and reset: one clock, ACLK. ARESETn is asynchronous and active-low.
- Reset values: all registers, RDATA, BRESP, RRESP, BVALID, RVALID and wr_pulse are 0. AWREADY, WREADY and ARREADY are 0 while ARESETn is low. They rise to 1 on the first ACLK edge after ARESETn is released.
- Decode: index = addr[ADDR_LSB +: clog2(NUM_REGS)], where ADDR_LSB = clog2(DATA_WIDTH/8). Low address bits below ADDR_LSB are ignored. An address >= NUM_REGS*(DATA_WIDTH/8) is out of range and gets SLVERR (2'b10). OKAY is 2'b00.
- Write FSM, WR_IDLE to WR_RESP:
  - WR_IDLE: AW and W are accepted independently, in either order or in the same cycle. AWREADY is 1 until AW is latched, then 0. WREADY behaves the same way for W.
  - Commit happens on the edge where the second of the two handshakes completes. On that edge: bytes with WSTRB[i]=1 update, wr_pulse[index] goes high for one cycle, BVALID=1 with BRESP set, and the FSM moves to WR_RESP.
  - An out-of-range write changes no register, raises no wr_pulse, and returns BRESP=SLVERR.
  - WR_RESP: AWREADY=WREADY=0. BVALID and BRESP are held stable until BREADY=1. On the B handshake, return to WR_IDLE with both readies at 1 in the next cycle.
  - A write with WSTRB=0 is still OKAY and still pulses wr_pulse, but leaves the data unchanged.
- Read FSM, RD_IDLE to RD_DATA:
  - RD_IDLE: ARREADY=1. On the AR handshake edge, capture RDATA/RRESP, set RVALID=1, set ARREADY=0 and move to RD_DATA.
  - Read latency is exactly 1 cycle from AR handshake to RVALID.
  - An out-of-range read returns RDATA=0 and RRESP=SLVERR.
  - RD_DATA: RDATA, RRESP and RVALID are held stable until RREADY=1. On the R handshake, set RVALID=0 and ARREADY=1.
- Read and write channels are fully independent and may be active in the same cycle.
- Same-edge read and write commit to the same register: the read returns the value from before the write.
- Reset asserted mid-transaction: the transaction is aborted and all outputs return to their reset values immediately (asynchronously). No partial write survives beyond the bytes already committed.

Optional Feature:
AXI_LITE_PROT_CHECK_EN
- Defined: any access with prot[1]=1 (non-secure) to register 0 is rejected with SLVERR. A rejected write changes nothing and raises no wr_pulse. A rejected read returns RDATA=0.
- Undefined: AWPROT and ARPROT are ignored entirely.

Test Plan:
- Reset release, then AW 0x08 and W 0xDEADBEEF with WSTRB=0xF in the same cycle -> BVALID the next cycle, BRESP=00; wr_pulse[2] for one cycle; reg_out reg2 = 0xDEADBEEF.
- W (0x11223344, WSTRB=0x5) three cycles before AW 0x08 -> reg2 = 0xDE22BE44; commit on the AW edge; BRESP=00.
- Read 0x08 with RREADY held low for 4 cycles -> RVALID 1 cycle after the AR handshake; RDATA=0xDE22BE44 stable throughout; ARREADY=0 until the R handshake.
- Write 0x40 (NUM_REGS=16) and read 0x44 -> BRESP=10, RRESP=10, RDATA=0, no register changes, no wr_pulse.
- BREADY held low for 5 cycles after a write -> AWREADY=WREADY=0 throughout; a second AW is not accepted until one cycle after the B handshake.
- Pull ARESETn low while in WR_RESP and RD_DATA -> BVALID=RVALID=0 immediately; all registers read 0 after release; with AXI_LITE_PROT_CHECK_EN defined, a write to 0x00 with AWPROT=3'b010 returns BRESP=10 and reg0 stays 0.

Source files
------------

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave register bank: byte-strobed writes, SLVERR on bad decode, flat register/pulse export.
// Optional build macro AXI_LITE_PROT_CHECK_EN rejects non-secure (prot[1]) accesses to register 0.
module axi_lite_reg_slave #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int NUM_REGS      = 16
) (
    input  logic                           ACLK,
    input  logic                           ARESETn,
    input  logic [ADDRESS_WIDTH-1:0]       AWADDR,
    input  logic [2:0]                     AWPROT,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDRESS_WIDTH-1:0]       ARADDR,
    input  logic [2:0]                     ARPROT,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    localparam int BYTES    = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(BYTES);
    localparam int IDX_W    = $clog2(NUM_REGS);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_LIMIT = ADDRESS_WIDTH'(NUM_REGS * BYTES);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {WR_IDLE = 1'b0, WR_RESP = 1'b1} wr_state_t;
    typedef enum logic {RD_IDLE = 1'b0, RD_DATA = 1'b1} rd_state_t;

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDRESS_WIDTH-1:0] addr);
        return addr[ADDR_LSB +: IDX_W];
    endfunction

    logic [DATA_WIDTH-1:0]    r_regs [NUM_REGS];
    wr_state_t                r_wr_state, w_wr_state_n;
    rd_state_t                r_rd_state, w_rd_state_n;
    logic                     r_aw_ready, w_aw_ready_n, r_w_ready, w_w_ready_n;
    logic                     r_aw_done, w_aw_done_n, r_w_done, w_w_done_n;
    logic                     r_bvalid, w_bvalid_n;
    logic [1:0]               r_bresp, w_bresp_n;
    logic                     r_ar_ready, w_ar_ready_n;
    logic                     r_rvalid, w_rvalid_n;
    logic [1:0]               r_rresp, w_rresp_n;
    logic [DATA_WIDTH-1:0]    r_rdata, w_rdata_n;
    logic [NUM_REGS-1:0]      r_wr_pulse, w_wr_pulse_n;
    logic [ADDRESS_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [BYTES-1:0]         r_wstrb;

    logic                     w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic [ADDRESS_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0]    w_wr_data;
    logic [BYTES-1:0]         w_wr_strb;
    logic [IDX_W-1:0]         w_wr_idx, w_rd_idx;
    logic                     w_wr_ok, w_rd_ok;

    assign w_aw_hs  = AWVALID && r_aw_ready;
    assign w_w_hs   = WVALID && r_w_ready;
    assign w_ar_hs  = ARVALID && r_ar_ready;
    assign w_commit = (r_wr_state == WR_IDLE) && (w_aw_hs || r_aw_done) && (w_w_hs || r_w_done);

    // The second handshake of a write may arrive live on the bus; the first one was latched.
    assign w_wr_addr = r_aw_done ? r_awaddr : AWADDR;
    assign w_wr_data = r_w_done ? r_wdata : WDATA;
    assign w_wr_strb = r_w_done ? r_wstrb : WSTRB;
    assign w_wr_idx  = addr_idx(w_wr_addr);
    assign w_rd_idx  = addr_idx(ARADDR);

`ifdef AXI_LITE_PROT_CHECK_EN
    logic [2:0] r_awprot;
    logic [2:0] w_wr_prot;

    assign w_wr_prot = r_aw_done ? r_awprot : AWPROT;
    assign w_wr_ok   = (w_wr_addr < ADDR_LIMIT) && !(w_wr_prot[1] && (w_wr_idx == '0));
    assign w_rd_ok   = (ARADDR < ADDR_LIMIT) && !(ARPROT[1] && (w_rd_idx == '0));

    // Write-protection capture alongside the write address
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_awprot <= 3'b000;
        end else if (w_aw_hs) begin
            r_awprot <= AWPROT;
        end
    end
`else
    logic w_unused;

    assign w_unused = ^{AWPROT, ARPROT};
    assign w_wr_ok  = (w_wr_addr < ADDR_LIMIT);
    assign w_rd_ok  = (ARADDR < ADDR_LIMIT);
`endif

    // Capture of whichever write half arrives first
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
        end else begin
            if (w_aw_hs) begin
                r_awaddr <= AWADDR;
            end
            if (w_w_hs) begin
                r_wdata <= WDATA;
                r_wstrb <= WSTRB;
            end
        end
    end

    // Register bank: byte-enabled update on a committed, accepted write
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= '0;
            end
        end else if (w_commit && w_wr_ok) begin
            for (int b = 0; b < BYTES; b++) begin
                if (w_wr_strb[b]) begin
                    r_regs[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
                end
            end
        end
    end

    // Write FSM next-state and next-output logic
    always_comb begin
        w_wr_state_n = r_wr_state;
        w_aw_ready_n = r_aw_ready;
        w_w_ready_n  = r_w_ready;
        w_aw_done_n  = r_aw_done;
        w_w_done_n   = r_w_done;
        w_bvalid_n   = r_bvalid;
        w_bresp_n    = r_bresp;
        case (r_wr_state)
            WR_IDLE: begin
                if (w_commit) begin
                    w_wr_state_n = WR_RESP;
                    w_aw_ready_n = 1'b0;
                    w_w_ready_n  = 1'b0;
                    w_aw_done_n  = 1'b0;
                    w_w_done_n   = 1'b0;
                    w_bvalid_n   = 1'b1;
                    w_bresp_n    = w_wr_ok ? RESP_OKAY : RESP_SLVERR;
                end else begin
                    w_aw_done_n  = r_aw_done || w_aw_hs;
                    w_w_done_n   = r_w_done || w_w_hs;
                    w_aw_ready_n = !(r_aw_done || w_aw_hs);
                    w_w_ready_n  = !(r_w_done || w_w_hs);
                end
            end
            WR_RESP: begin
                if (BREADY) begin
                    w_wr_state_n = WR_IDLE;
                    w_aw_ready_n = 1'b1;
                    w_w_ready_n  = 1'b1;
                    w_bvalid_n   = 1'b0;
                end else begin
                    w_bvalid_n   = 1'b1;
                end
            end
            default: begin
                w_wr_state_n = WR_IDLE;
                w_aw_ready_n = 1'b0;
                w_w_ready_n  = 1'b0;
                w_aw_done_n  = 1'b0;
                w_w_done_n   = 1'b0;
                w_bvalid_n   = 1'b0;
                w_bresp_n    = RESP_OKAY;
            end
        endcase
    end

    // One-hot write pulse for the committed register
    always_comb begin
        w_wr_pulse_n = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_commit && w_wr_ok && (w_wr_idx == IDX_W'(k))) begin
                w_wr_pulse_n[k] = 1'b1;
            end else begin
                w_wr_pulse_n[k] = 1'b0;
            end
        end
    end

    // Read FSM; data is sampled before any same-edge write lands
    always_comb begin
        w_rd_state_n = r_rd_state;
        w_ar_ready_n = r_ar_ready;
        w_rvalid_n   = r_rvalid;
        w_rresp_n    = r_rresp;
        w_rdata_n    = r_rdata;
        case (r_rd_state)
            RD_IDLE: begin
                if (w_ar_hs) begin
                    w_rd_state_n = RD_DATA;
                    w_ar_ready_n = 1'b0;
                    w_rvalid_n   = 1'b1;
                    w_rresp_n    = w_rd_ok ? RESP_OKAY : RESP_SLVERR;
                    w_rdata_n    = w_rd_ok ? r_regs[w_rd_idx] : '0;
                end else begin
                    w_ar_ready_n = 1'b1;
                end
            end
            RD_DATA: begin
                if (RREADY) begin
                    w_rd_state_n = RD_IDLE;
                    w_ar_ready_n = 1'b1;
                    w_rvalid_n   = 1'b0;
                end else begin
                    w_rvalid_n   = 1'b1;
                end
            end
            default: begin
                w_rd_state_n = RD_IDLE;
                w_ar_ready_n = 1'b0;
                w_rvalid_n   = 1'b0;
                w_rresp_n    = RESP_OKAY;
                w_rdata_n    = '0;
            end
        endcase
    end

    // State and registered-output update for both channels
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_wr_state <= WR_IDLE;
            r_rd_state <= RD_IDLE;
            r_aw_ready <= 1'b0;
            r_w_ready  <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= 2'b00;
            r_ar_ready <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rresp    <= 2'b00;
            r_rdata    <= '0;
            r_wr_pulse <= '0;
        end else begin
            r_wr_state <= w_wr_state_n;
            r_rd_state <= w_rd_state_n;
            r_aw_ready <= w_aw_ready_n;
            r_w_ready  <= w_w_ready_n;
            r_aw_done  <= w_aw_done_n;
            r_w_done   <= w_w_done_n;
            r_bvalid   <= w_bvalid_n;
            r_bresp    <= w_bresp_n;
            r_ar_ready <= w_ar_ready_n;
            r_rvalid   <= w_rvalid_n;
            r_rresp    <= w_rresp_n;
            r_rdata    <= w_rdata_n;
            r_wr_pulse <= w_wr_pulse_n;
        end
    end

    assign AWREADY  = r_aw_ready;
    assign WREADY   = r_w_ready;
    assign BVALID   = r_bvalid;
    assign BRESP    = r_bresp;
    assign ARREADY  = r_ar_ready;
    assign RVALID   = r_rvalid;
    assign RRESP    = r_rresp;
    assign RDATA    = r_rdata;
    assign wr_pulse = r_wr_pulse;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_out
        assign reg_out[k*DATA_WIDTH +: DATA_WIDTH] = r_regs[k];
    end

endmodule
